// File: rtl/leds_pkg.sv
// Shared definitions for the LED command scheduler: state encoding,
// one-hot LED command constants and the LED count.
package leds_pkg;

  localparam int N_LEDS = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  localparam logic [N_LEDS-1:0] LED_OFF = 3'b000;
  localparam logic [N_LEDS-1:0] LED0    = 3'b001;
  localparam logic [N_LEDS-1:0] LED1    = 3'b010;
  localparam logic [N_LEDS-1:0] LED2    = 3'b100;

endpackage

// File: rtl/leds_sequencer_if.sv
// Request/grant/command bundle between the input conditioning (master)
// and the LED scheduler (slave).
interface leds_sequencer_if;
  import leds_pkg::*;

  logic [N_LEDS-1:0] req;
  logic [N_LEDS-1:0] ack;
  logic [N_LEDS-1:0] cmd;
  logic              mode_auto;
  logic              busy;

  modport master (output req, input ack, input cmd, input mode_auto, input busy);
  modport slave  (input req, output ack, output cmd, output mode_auto, output busy);

endinterface

// File: rtl/leds_sequencer_arb.sv
// Three-way combinational round-robin picker. The search starts one
// position after ptr (ptr=2 wraps to bit 0); idx mirrors the grant and
// holds ptr when nothing is requested.
module rr_arbiter3
  import leds_pkg::*;
(
  input  logic [N_LEDS-1:0] request,
  input  logic [1:0]        ptr,
  output logic [N_LEDS-1:0] grant,
  output logic [1:0]        idx
);

  logic [1:0] start;
  logic [1:0] cand;
  logic       found;

  // Walk the three positions starting after the last winner, take the first hit.
  always_comb begin
    grant = LED_OFF;
    idx   = ptr;
    found = 1'b0;
    cand  = 2'd0;
    start = (ptr >= 2'd2) ? 2'd0 : ptr + 2'd1;
    for (int k = 0; k < N_LEDS; k++) begin
      cand = 2'((int'(start) + k) % N_LEDS);
      if (!found && request[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/leds_sequencer.sv
// LED command scheduler: shares three LEDs between three requesters with
// round-robin arbitration, holds each manual grant for HOLD_CYCLES, and
// falls back to an automatic sequence after IDLE_TIMEOUT idle cycles.
// Build option: LEDS_SEQ_PINGPONG_EN selects a ping-pong automatic
// sequence (001,010,100,010,001,...) instead of the plain rotation.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | all LEDs off, counting idle cycles toward automatic mode
// ST_MANUAL | granted LED on for HOLD_CYCLES, other requests queued
// ST_AUTO   | automatic LED sequence, any request preempts it
module leds_sequencer
  import leds_pkg::*;
#(
  parameter int HOLD_CYCLES      = 25,
  parameter int AUTO_STEP_CYCLES = 10,
  parameter int IDLE_TIMEOUT     = 40
) (
  input logic             clk,
  input logic             reset,
  leds_sequencer_if.slave bus
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = $clog2(AUTO_STEP_CYCLES);
  localparam int IW = $clog2(IDLE_TIMEOUT);

  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_TC = SW'(AUTO_STEP_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_TC = IW'(IDLE_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [N_LEDS-1:0] cmd_q, cmd_d;
  logic [N_LEDS-1:0] ack_q, ack_d;
  logic              mode_auto_q, mode_auto_d;
  logic              busy_q, busy_d;
  logic [N_LEDS-1:0] pending_q, pending_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [SW-1:0]     step_q, step_d;
  logic [IW-1:0]     idle_q, idle_d;
`ifdef LEDS_SEQ_PINGPONG_EN
  logic              dir_down_q, dir_down_d;
`endif

  logic [N_LEDS-1:0] arb_req;
  logic [N_LEDS-1:0] arb_grant;
  logic [1:0]        arb_idx;
  logic [N_LEDS-1:0] auto_next;
  logic [N_LEDS-1:0] req_other;

  // Pending never holds the LED currently on, and a request for that LED
  // restarts its hold instead of reaching the arbiter at terminal count.
  assign arb_req   = bus.req | pending_q;
  assign req_other = bus.req & ~cmd_q;

  rr_arbiter3 u_arb (
    .request (arb_req),
    .ptr     (ptr_q),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  // Next LED of the automatic sequence (and direction for ping-pong).
  always_comb begin
    auto_next = LED0;
`ifdef LEDS_SEQ_PINGPONG_EN
    dir_down_d = dir_down_q;
    unique case (cmd_q)
      LED0: begin auto_next = LED1; dir_down_d = 1'b0; end
      LED1: auto_next = dir_down_q ? LED0 : LED2;
      LED2: begin auto_next = LED1; dir_down_d = 1'b1; end
      default: begin auto_next = LED0; dir_down_d = 1'b0; end
    endcase
    if (state_q != ST_AUTO) begin
      dir_down_d = 1'b0;
    end else if (|bus.req || step_q != STEP_TC) begin
      dir_down_d = dir_down_q;
    end
`else
    unique case (cmd_q)
      LED0:    auto_next = LED1;
      LED1:    auto_next = LED2;
      default: auto_next = LED0;
    endcase
`endif
  end

  // FSM next state, counters, pending queue and registered outputs.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    ack_d       = LED_OFF;
    mode_auto_d = mode_auto_q;
    busy_d      = busy_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    step_d      = step_q;
    idle_d      = idle_q;

    unique case (state_q)
      ST_IDLE: begin
        cmd_d       = LED_OFF;
        mode_auto_d = 1'b0;
        busy_d      = 1'b0;
        if (|bus.req) begin
          state_d   = ST_MANUAL;
          cmd_d     = arb_grant;
          ack_d     = arb_grant;
          busy_d    = 1'b1;
          pending_d = arb_req & ~arb_grant;
          ptr_d     = arb_idx;
          hold_d    = '0;
          idle_d    = '0;
        end else if (idle_q == IDLE_TC) begin
          state_d     = ST_AUTO;
          cmd_d       = LED0;
          mode_auto_d = 1'b1;
          step_d      = '0;
          idle_d      = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      ST_MANUAL: begin
        if (|(bus.req & cmd_q)) begin
          hold_d    = '0;
          pending_d = pending_q | req_other;
        end else if (hold_q == HOLD_TC) begin
          hold_d = '0;
          if (|arb_req) begin
            cmd_d     = arb_grant;
            ack_d     = arb_grant;
            pending_d = arb_req & ~arb_grant;
            ptr_d     = arb_idx;
          end else begin
            state_d = ST_IDLE;
            cmd_d   = LED_OFF;
            busy_d  = 1'b0;
            idle_d  = '0;
          end
        end else begin
          hold_d    = hold_q + 1'b1;
          pending_d = pending_q | req_other;
        end
      end

      ST_AUTO: begin
        if (|bus.req) begin
          state_d     = ST_MANUAL;
          cmd_d       = arb_grant;
          ack_d       = arb_grant;
          mode_auto_d = 1'b0;
          busy_d      = 1'b1;
          pending_d   = LED_OFF;
          ptr_d       = arb_idx;
          hold_d      = '0;
          step_d      = '0;
        end else if (step_q == STEP_TC) begin
          step_d = '0;
          cmd_d  = auto_next;
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_d       = LED_OFF;
        mode_auto_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; ptr resets to 2 so the first search starts at LED0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= LED_OFF;
      ack_q       <= LED_OFF;
      mode_auto_q <= 1'b0;
      busy_q      <= 1'b0;
      pending_q   <= LED_OFF;
      ptr_q       <= 2'd2;
      hold_q      <= '0;
      step_q      <= '0;
      idle_q      <= '0;
`ifdef LEDS_SEQ_PINGPONG_EN
      dir_down_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      ack_q       <= ack_d;
      mode_auto_q <= mode_auto_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      step_q      <= step_d;
      idle_q      <= idle_d;
`ifdef LEDS_SEQ_PINGPONG_EN
      dir_down_q  <= dir_down_d;
`endif
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.ack       = ack_q;
  assign bus.mode_auto = mode_auto_q;
  assign bus.busy      = busy_q;

endmodule
